// File: rtl/deskew_lane_fifo_pkg.sv
// ---------------------------------------------------------------------------
// deskew_pkg
// Shared definitions for the per-lane deskew delay buffer:
//   - state_t      : one-hot controller state (IDLE, FILL, RUN)
//   - NB_DATA_DEF  : default PCS block width
//   - MAX_SKEW_DEF : default buffer depth (power of 2)
// ---------------------------------------------------------------------------
package deskew_pkg;

    localparam int NB_DATA_DEF  = 66;
    localparam int MAX_SKEW_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_FILL = 3'b010,
        ST_RUN  = 3'b100
    } state_t;

endpackage

// File: rtl/deskew_lane_fifo_if.sv
// ---------------------------------------------------------------------------
// deskew_lane_fifo_if
// Lane-side bus between the deskew controller (master) and one lane delay
// buffer (slave).
//   i_enable, i_valid      : accepted cycle = i_enable && i_valid
//   i_flush                : synchronous resync
//   i_write_enb/i_read_enb : store / produce a word this accepted cycle
//   i_set_delay, i_delay   : delay programming strobe and value
//   i_data                 : lane block in
//   o_data, o_valid        : delayed block out
//   o_delay, o_locked      : latched delay, RUN indication
//   o_delay_err            : rejected set strobe pulse
// ---------------------------------------------------------------------------
interface deskew_lane_fifo_if
    import deskew_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_DELAY_COUNT = $clog2(MAX_SKEW_DEF)
);
    logic                      i_enable;
    logic                      i_valid;
    logic                      i_flush;
    logic                      i_write_enb;
    logic                      i_read_enb;
    logic                      i_set_delay;
    logic [NB_DELAY_COUNT-1:0] i_delay;
    logic [NB_DATA-1:0]        i_data;
    logic [NB_DATA-1:0]        o_data;
    logic                      o_valid;
    logic [NB_DELAY_COUNT-1:0] o_delay;
    logic                      o_locked;
    logic                      o_delay_err;

    modport master (
        output i_enable, i_valid, i_flush, i_write_enb, i_read_enb,
               i_set_delay, i_delay, i_data,
        input  o_data, o_valid, o_delay, o_locked, o_delay_err
    );

    modport slave (
        input  i_enable, i_valid, i_flush, i_write_enb, i_read_enb,
               i_set_delay, i_delay, i_data,
        output o_data, o_valid, o_delay, o_locked, o_delay_err
    );
endinterface

// File: rtl/deskew_lane_fifo_delay_ram.sv
// ---------------------------------------------------------------------------
// deskew_delay_ram
// Simple dual-port storage: synchronous write, asynchronous read. Contents
// are intentionally not reset; the controller never reads a slot that has
// not been written since the last flush.
//   i_clock              : write clock
//   i_wr_en, i_wr_addr,
//   i_wr_data            : write port
//   i_rd_addr, o_rd_data : combinational read port
// ---------------------------------------------------------------------------
module deskew_delay_ram
    import deskew_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int DEPTH    = MAX_SKEW_DEF,
    parameter int NB_ADDR  = $clog2(DEPTH)
) (
    input  logic               i_clock,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);
    logic [NB_DATA-1:0] mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];
endmodule

// File: rtl/deskew_lane_fifo.sv
// ---------------------------------------------------------------------------
// deskew_lane_fifo
// Per-lane programmable delay buffer for PCS lane deskew. Blocks are stored
// continuously in a circular buffer; once a delay is latched, each read
// returns the block written `delay` accepted write cycles earlier.
//   i_clock   : clock
//   i_reset_n : asynchronous active-low reset
//   bus       : deskew_lane_fifo_if.slave (handshake, data, status)
// Build option: DESKEW_FIFO_OUT_REG_EN adds one output register stage on
// o_data/o_valid (latency delay+2 instead of delay+1).
// MAX_SKEW must be a power of 2 so pointer arithmetic wraps naturally.
// ---------------------------------------------------------------------------
module deskew_lane_fifo
    import deskew_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int MAX_SKEW       = MAX_SKEW_DEF,
    parameter int NB_DELAY_COUNT = $clog2(MAX_SKEW)
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    deskew_lane_fifo_if.slave   bus
);
    localparam int NB_FILL = NB_DELAY_COUNT + 1;
    localparam logic [NB_FILL-1:0]        FILL_MAX = NB_FILL'(MAX_SKEW);
    localparam logic [NB_FILL-1:0]        FILL_ONE = NB_FILL'(1);
    localparam logic [NB_DELAY_COUNT-1:0] PTR_ONE  = NB_DELAY_COUNT'(1);

    state_t                    state;
    logic [NB_DELAY_COUNT-1:0] wr_ptr;
    logic [NB_FILL-1:0]        fill;
    logic [NB_DELAY_COUNT-1:0] delay;
    logic                      locked;
    logic                      delay_err;
    logic [NB_DATA-1:0]        data_p0;
    logic                      vld_p0;

    logic                      accepted;
    logic                      do_write;
    logic                      set_req;
    logic                      set_ok;
    logic                      set_bad;
    logic                      do_read;
    logic [NB_DELAY_COUNT-1:0] rd_delay;
    logic [NB_DELAY_COUNT-1:0] rd_addr;
    logic [NB_DATA-1:0]        ram_rd_data;
    logic [NB_DATA-1:0]        rd_word;

    assign accepted = bus.i_enable & bus.i_valid;
    // A flush in the same cycle discards the write.
    assign do_write = accepted & bus.i_write_enb & ~bus.i_flush;

    // The set strobe is only honoured while filling; fill is the count before
    // this cycle's write.
    assign set_req  = (state == ST_FILL) & accepted & bus.i_set_delay;
    assign set_ok   = set_req & ({1'b0, bus.i_delay} <= fill);
    assign set_bad  = set_req & ~({1'b0, bus.i_delay} <= fill);

    // A set and a read in the same cycle produce the first output word
    // immediately, using the incoming delay rather than the latched one.
    assign do_read  = accepted & bus.i_read_enb & ((state == ST_RUN) | set_ok);
    assign rd_delay = set_ok ? bus.i_delay : delay;
    assign rd_addr  = wr_ptr - rd_delay;
    assign rd_word  = (rd_delay == '0) ? bus.i_data : ram_rd_data;

    deskew_delay_ram #(
        .NB_DATA (NB_DATA),
        .DEPTH   (MAX_SKEW),
        .NB_ADDR (NB_DELAY_COUNT)
    ) u_ram (
        .i_clock   (i_clock),
        .i_wr_en   (do_write),
        .i_wr_addr (wr_ptr),
        .i_wr_data (bus.i_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (ram_rd_data)
    );

    // Stage p0: pointers, state machine and registered outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            delay     <= '0;
            locked    <= 1'b0;
            delay_err <= 1'b0;
            data_p0   <= '0;
            vld_p0    <= 1'b0;
        end else if (bus.i_flush) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            fill      <= '0;
            delay     <= '0;
            locked    <= 1'b0;
            delay_err <= 1'b0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0    <= do_read;
            delay_err <= set_bad;

            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (fill != FILL_MAX) begin
                    fill <= fill + FILL_ONE;
                end
            end

            if (do_read) begin
                data_p0 <= rd_word;
            end

            unique case (state)
                ST_IDLE: begin
                    if (do_write) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (set_ok) begin
                        delay  <= bus.i_delay;
                        locked <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    locked <= 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef DESKEW_FIFO_OUT_REG_EN
    logic [NB_DATA-1:0] data_p1;
    logic               vld_p1;

    // Stage p1: optional output retiming register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (bus.i_flush) begin
            vld_p1  <= 1'b0;
        end else begin
            data_p1 <= data_p0;
            vld_p1  <= vld_p0;
        end
    end

    assign bus.o_data  = data_p1;
    assign bus.o_valid = vld_p1;
`else
    assign bus.o_data  = data_p0;
    assign bus.o_valid = vld_p0;
`endif

    assign bus.o_delay     = delay;
    assign bus.o_locked    = locked;
    assign bus.o_delay_err = delay_err;

endmodule

// File: tb/tb_deskew_lane_fifo.sv
// ---------------------------------------------------------------------------
// tb_deskew_lane_fifo
// Self-checking bench for deskew_lane_fifo: a directed vector table, hand
// sequences for multi-cycle behaviour, and randomized traffic checked against
// a history-queue reference model.
// ---------------------------------------------------------------------------
module tb_deskew_lane_fifo;

    localparam int NB_DATA = 66;
    localparam int NB_DLY  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    deskew_lane_fifo_if #(.NB_DATA(NB_DATA), .NB_DELAY_COUNT(NB_DLY)) bus();

    deskew_lane_fifo dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ctl bits: {enable, valid, flush, write, read, set}
    // eflg bits: {o_valid, o_locked, o_delay_err}
    typedef struct {
        logic [5:0]         ctl;
        logic [NB_DLY-1:0]  dly;
        logic [NB_DATA-1:0] din;
        logic [2:0]         eflg;
        logic [NB_DLY-1:0]  edly;
        logic [NB_DATA-1:0] edat;
    } vec_t;

    vec_t tbl [15];

    // Reference model state: words written since the last flush (newest at
    // the back, at most 16 kept), plus the expected registered outputs.
    logic [NB_DATA-1:0] hist [$];
    bit                 m_started;
    bit                 m_locked;
    int                 m_delay;
    logic [NB_DATA-1:0] e_data;
    logic               e_valid;
    logic               e_err;

    task automatic chk(input string name, input logic [NB_DATA-1:0] act,
                       input logic [NB_DATA-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_started = 0;
        m_locked  = 0;
        m_delay   = 0;
        e_data    = '0;
        e_valid   = 1'b0;
        e_err     = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] ctl, input logic [NB_DLY-1:0] dly,
                              input logic [NB_DATA-1:0] din);
        bit acc;
        bit rd_now;
        int d;
        if (ctl[3]) begin
            hist.delete();
            m_started = 0;
            m_locked  = 0;
            m_delay   = 0;
            e_valid   = 1'b0;
            e_err     = 1'b0;
            return;
        end
        acc     = ctl[5] && ctl[4];
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (!acc) return;
        rd_now = 0;
        d      = m_delay;
        if (m_started && !m_locked && ctl[0]) begin
            if (int'(dly) <= hist.size()) begin
                m_delay  = int'(dly);
                m_locked = 1;
                d        = m_delay;
                rd_now   = ctl[1];
            end else begin
                e_err = 1'b1;
            end
        end else if (m_locked && ctl[1]) begin
            rd_now = 1;
        end
        if (rd_now) begin
            e_data  = (d == 0) ? din : hist[hist.size() - d];
            e_valid = 1'b1;
        end
        if (ctl[2]) begin
            hist.push_back(din);
            m_started = 1;
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    task automatic model_check();
        chk("m_data",   bus.o_data, e_data);
        chk("m_valid",  NB_DATA'(bus.o_valid), NB_DATA'(e_valid));
        chk("m_locked", NB_DATA'(bus.o_locked), NB_DATA'(m_locked));
        chk("m_delay",  NB_DATA'(bus.o_delay), NB_DATA'(m_delay));
        chk("m_err",    NB_DATA'(bus.o_delay_err), NB_DATA'(e_err));
    endtask

    task automatic cyc(input logic [5:0] ctl, input logic [NB_DLY-1:0] dly,
                       input logic [NB_DATA-1:0] din);
        bus.i_enable    = ctl[5];
        bus.i_valid     = ctl[4];
        bus.i_flush     = ctl[3];
        bus.i_write_enb = ctl[2];
        bus.i_read_enb  = ctl[1];
        bus.i_set_delay = ctl[0];
        bus.i_delay     = dly;
        bus.i_data      = din;
        model_step(ctl, dly, din);
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"},  bus.o_data, '0);
        chk({tag, "_valid"}, NB_DATA'(bus.o_valid), '0);
        chk({tag, "_delay"}, NB_DATA'(bus.o_delay), '0);
        chk({tag, "_lock"},  NB_DATA'(bus.o_locked), '0);
        chk({tag, "_err"},   NB_DATA'(bus.o_delay_err), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ctl;
        logic [NB_DATA-1:0] rdat;

        bus.i_enable = 1'b0; bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        bus.i_write_enb = 1'b0; bus.i_read_enb = 1'b0; bus.i_set_delay = 1'b0;
        bus.i_delay = '0; bus.i_data = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: error, accept, RUN ignores set, re-emit, gap, flush, delay 0
        tbl[0]  = '{6'b110100, 4'd0, 66'h11, 3'b000, 4'd0, 66'h0};
        tbl[1]  = '{6'b110100, 4'd0, 66'h22, 3'b000, 4'd0, 66'h0};
        tbl[2]  = '{6'b110100, 4'd0, 66'h33, 3'b000, 4'd0, 66'h0};
        tbl[3]  = '{6'b110101, 4'd6, 66'h44, 3'b001, 4'd0, 66'h0};
        tbl[4]  = '{6'b110100, 4'd0, 66'h55, 3'b000, 4'd0, 66'h0};
        tbl[5]  = '{6'b110111, 4'd3, 66'h66, 3'b110, 4'd3, 66'h33};
        tbl[6]  = '{6'b110110, 4'd0, 66'h77, 3'b110, 4'd3, 66'h44};
        tbl[7]  = '{6'b110111, 4'd1, 66'h88, 3'b110, 4'd3, 66'h55};
        tbl[8]  = '{6'b110010, 4'd0, 66'h99, 3'b110, 4'd3, 66'h66};
        tbl[9]  = '{6'b110010, 4'd0, 66'h99, 3'b110, 4'd3, 66'h66};
        tbl[10] = '{6'b100110, 4'd0, 66'h99, 3'b010, 4'd3, 66'h66};
        tbl[11] = '{6'b111100, 4'd0, 66'hAA, 3'b000, 4'd0, 66'h66};
        tbl[12] = '{6'b110111, 4'd0, 66'h99, 3'b000, 4'd0, 66'h66};
        tbl[13] = '{6'b110111, 4'd0, 66'hAA, 3'b110, 4'd0, 66'hAA};
        tbl[14] = '{6'b110110, 4'd0, 66'hBB, 3'b110, 4'd0, 66'hBB};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].ctl, tbl[i].dly, tbl[i].din);
            chk($sformatf("tbl%0d_valid", i), NB_DATA'(bus.o_valid), NB_DATA'(tbl[i].eflg[2]));
            chk($sformatf("tbl%0d_lock", i),  NB_DATA'(bus.o_locked), NB_DATA'(tbl[i].eflg[1]));
            chk($sformatf("tbl%0d_err", i),   NB_DATA'(bus.o_delay_err), NB_DATA'(tbl[i].eflg[0]));
            chk($sformatf("tbl%0d_delay", i), NB_DATA'(bus.o_delay), NB_DATA'(tbl[i].edly));
            chk($sformatf("tbl%0d_data", i),  bus.o_data, tbl[i].edat);
        end

        // Delay 5: set + read after 8 writes
        cyc(6'b111000, 4'd0, '0);
        for (int n = 1; n <= 8; n++) cyc(6'b110100, 4'd0, NB_DATA'(n));
        for (int n = 9; n <= 30; n++) begin
            cyc((n == 9) ? 6'b110111 : 6'b110110, 4'd5, NB_DATA'(n));
            chk("d5_data", bus.o_data, NB_DATA'(n - 5));
            chk("d5_lock", NB_DATA'(bus.o_locked), NB_DATA'(1));
        end

        // Delay 15 across pointer wrap, 40 writes
        cyc(6'b111000, 4'd0, '0);
        for (int n = 1; n <= 15; n++) cyc(6'b110100, 4'd0, NB_DATA'(n + 1000));
        for (int n = 16; n <= 40; n++) begin
            cyc((n == 16) ? 6'b110111 : 6'b110110, 4'd15, NB_DATA'(n + 1000));
            chk("wrap_data", bus.o_data, NB_DATA'(n - 15 + 1000));
            chk("wrap_valid", NB_DATA'(bus.o_valid), NB_DATA'(1));
        end

        // Delay 4 with a 3-cycle valid gap
        cyc(6'b111000, 4'd0, '0);
        for (int n = 1; n <= 4; n++) cyc(6'b110100, 4'd0, NB_DATA'(n + 500));
        for (int n = 5; n <= 7; n++) begin
            cyc((n == 5) ? 6'b110111 : 6'b110110, 4'd4, NB_DATA'(n + 500));
            chk("gap_pre", bus.o_data, NB_DATA'(n - 4 + 500));
        end
        for (int g = 0; g < 3; g++) begin
            cyc(6'b100110, 4'd4, NB_DATA'(777));
            chk("gap_hold", bus.o_data, NB_DATA'(3 + 500));
            chk("gap_vld0", NB_DATA'(bus.o_valid), '0);
        end
        for (int n = 8; n <= 12; n++) begin
            cyc(6'b110110, 4'd4, NB_DATA'(n + 500));
            chk("gap_post", bus.o_data, NB_DATA'(n - 4 + 500));
        end

        // Flush in RUN, then asynchronous reset for part of a cycle
        cyc(6'b111110, 4'd0, NB_DATA'(5));
        chk("fl_lock",  NB_DATA'(bus.o_locked), '0);
        chk("fl_valid", NB_DATA'(bus.o_valid), '0);
        chk("fl_hold",  bus.o_data, NB_DATA'(8 + 500));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        model_reset();
        #2;
        rst_n = 1'b1;
        cyc(6'b110111, 4'd0, NB_DATA'(1));
        chk("post_idle_lock", NB_DATA'(bus.o_locked), '0);
        cyc(6'b110110, 4'd0, NB_DATA'(2));
        chk("post_norearm", NB_DATA'(bus.o_valid), '0);
        cyc(6'b110111, 4'd1, NB_DATA'(3));
        chk("post_relock", NB_DATA'(bus.o_locked), NB_DATA'(1));
        chk("post_data",   bus.o_data, NB_DATA'(2));

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            ctl[5] = ($urandom_range(0, 9) != 0);
            ctl[4] = ($urandom_range(0, 99) < 85);
            ctl[3] = ($urandom_range(0, 63) == 0);
            ctl[2] = ($urandom_range(0, 9) != 0);
            ctl[1] = ($urandom_range(0, 9) < 7);
            ctl[0] = ($urandom_range(0, 9) == 0);
            rdat   = {$urandom(), $urandom(), $urandom()};
            cyc(ctl, NB_DLY'($urandom_range(0, 15)), rdat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/deskew_lane_fifo.md
# deskew_lane_fifo

Per-lane programmable delay buffer for the 100GbE PCS lane deskew stage, one instance per PCS lane, sitting directly downstream of the deskew controller. While the controller measures skew, the block continuously stores the lane's blocks in a circular buffer. When it receives a delay value and a one-cycle set strobe, it releases each block exactly `delay` accepted cycles later, so all lanes leave the stage aligned. It also reports delay-programming errors and supports a synchronous flush on resync.

## Interface
- `NB_DATA`, 66, width of one PCS block.
- `MAX_SKEW`, 16, buffer depth in words; must be a power of 2.
- `NB_DELAY_COUNT`, `$clog2(MAX_SKEW)`, width of the delay value and of the pointers.

Ports:
- `i_clock`  in  1  single clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  block enable.
- `i_valid`  in  1  data-valid qualifier; an *accepted cycle* is `i_enable && i_valid`.
- `i_flush`  in  1  synchronous resync/flush, active-high.
- `i_write_enb`  in  1  store `i_data` this accepted cycle.
- `i_read_enb`  in  1  produce an output word this accepted cycle.
- `i_set_delay`  in  1  one-cycle strobe that latches `i_delay`.
- `i_delay`  in  `NB_DELAY_COUNT`  delay in accepted write cycles, range 0..MAX_SKEW-1.
- `i_data`  in  `NB_DATA`  lane block.
- `o_data`  out  `NB_DATA`  delayed block; registered.
- `o_valid`  out  1  `o_data` is new this cycle.
- `o_delay`  out  `NB_DELAY_COUNT`  delay currently latched.
- `o_locked`  out  1  high while in state RUN.
- `o_delay_err`  out  1  one-cycle pulse when a set strobe is rejected.

## Operation
- Storage and pointers:
  - `mem[MAX_SKEW]` holds the lane blocks.
  - `wr_ptr` points to the next slot to write and wraps modulo MAX_SKEW.
  - `fill` is the number of words written, saturating at MAX_SKEW.
- Write: on an accepted cycle with `i_write_enb`, `mem[wr_ptr] <= i_data` and `wr_ptr` increments. Writes happen in every state.
- Read source for delay `d`:
  - `d == 0`: `i_data`.
  - `d > 0`: `mem[wr_ptr - d]`, the word written `d` accepted cycles earlier. Subtraction is modulo MAX_SKEW.
- State machine:
  - IDLE → FILL on the first accepted write.
  - FILL: on an accepted `i_set_delay`:
    - if `i_delay <= fill`: latch `delay <= i_delay` and go to RUN;
    - otherwise pulse `o_delay_err`, stay in FILL and leave `delay` unchanged.
  - RUN: on an accepted cycle with `i_read_enb`, `o_data <=` read source and `o_valid <= 1`. `i_set_delay` is ignored in RUN; the delay can only change through a flush.
  - Any state → IDLE on `i_flush`.
- Simultaneous set and read (the controller asserts both in the same cycle): the transition to RUN and the first read happen in that same cycle, and that read uses `i_delay` directly.
- Read with no write: `wr_ptr` stalls, so the same word is re-emitted. This is legal.
- `i_valid` or `i_enable` low: pointers, state and `o_data` hold, and `o_valid <= 0`.
- `i_flush` takes priority over every other input. It clears `wr_ptr`, `fill`, `delay`, `o_valid` and `o_locked`; memory contents are not cleared. A flush together with a write discards the write.
- Reset (asynchronous, mid-operation allowed): state IDLE, pointers 0, `fill` 0. Output reset values:
  - `o_data` = 0
  - `o_valid` = 0
  - `o_delay` = 0
  - `o_locked` = 0
  - `o_delay_err` = 0

## Timing
- `o_data` is registered, so end-to-end latency is `delay + 1` accepted cycles from `i_data` to `o_data`.
- `o_delay_err` appears 1 cycle after the rejected strobe.
- `o_locked` rises 1 cycle after the accepted strobe.
- Accepted delay range is 0..MAX_SKEW-1.
- `i_delay` cannot encode MAX_SKEW, so no further range check is needed.

## Configuration
- `DESKEW_FIFO_OUT_REG_EN`:
  - Defined: one extra output pipeline register on `o_data` and `o_valid`, with its own reset to 0. Latency becomes `delay + 2`.
  - Undefined: latency is `delay + 1` as specified above.
  - `o_locked`, `o_delay` and `o_delay_err` timing is the same in both builds.

## Structure
- Package `deskew_pkg` holds:
  - the state encodings (IDLE, FILL, RUN, one-hot, 3 bits);
  - the defaults for MAX_SKEW and NB_DATA.
- Sub-module `deskew_delay_ram`: a simple dual-port memory with a synchronous write port and an asynchronous read port. It is `MAX_SKEW × NB_DATA` and is not reset.

## Test plan
- Delay 5: write 1, 2, 3, … continuously and assert set + read after 8 writes → `o_data` equals `n-5` one cycle after word `n` is written; `o_locked` = 1.
- Delay 0: set strobe after 1 write → `o_data` equals the previous cycle's `i_data`; no error pulse.
- Error: delay 6 after 3 writes → one-cycle `o_delay_err` pulse, state stays FILL, `o_valid` = 0. A later set with delay 3 is accepted.
- Wrap-around: delay 15 with 40 writes → output sequence is exactly the input shifted by 15 across each pointer wrap.
- `i_valid` gaps: drop `i_valid` for 3 cycles at delay 4 → `o_data` holds, `o_valid` = 0, and the sequence resumes with no missing or duplicated word.
- Reset: assert `i_flush` in RUN, then async `i_reset_n` low for a partial cycle → all outputs are 0 immediately on reset; after release, the block returns to IDLE and a re-set strobe is needed.
